// File: rtl/alarm_beep_pkg.sv
// Shared definitions for the alarm beep timer: FSM state encoding and default widths.
package alarm_beep_pkg;

   localparam int DEF_CW  = 4;
   localparam int DEF_BW  = 3;
   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2
   } state_e;

endpackage

// File: rtl/alarm_beep_timer_down_counter.sv
// Loadable down counter with enable and zero flag; saturates at zero.
module beep_down_counter #(
   parameter int CW = alarm_beep_pkg::DEF_CW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          en,
   input  logic [CW-1:0] load_val,
   output logic [CW-1:0] count,
   output logic          zero
);

   logic [CW-1:0] count_r;

   // Counter register: load wins over decrement, never wraps below zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= {CW{1'b0}};
      end else if (load) begin
         count_r <= load_val;
      end else if (en && (count_r != {CW{1'b0}})) begin
         count_r <= count_r - CW'(1'b1);
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;
   assign zero  = (count_r == {CW{1'b0}});

endmodule

// File: rtl/alarm_beep_timer.sv
// Alarm beep sequencer: bursts of ON/OFF phases timed by tick strobes.
// Optional freeze input enabled by defining ALARM_BEEP_PAUSE_EN.
module alarm_beep_timer #(
   parameter int CW = alarm_beep_pkg::DEF_CW,
   parameter int BW = alarm_beep_pkg::DEF_BW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tick,
   input  logic          start,
   input  logic          stop,
   input  logic [CW-1:0] t_on,
   input  logic [CW-1:0] t_off,
   input  logic [BW-1:0] burst,
`ifdef ALARM_BEEP_PAUSE_EN
   input  logic          pause,
`endif
   output logic          beep,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] count
);

   import alarm_beep_pkg::*;

   state_e        state_r;
   state_e        state_s;
   logic [BW-1:0] burst_left_r;
   logic [BW-1:0] burst_left_s;
   logic          beep_r;
   logic          busy_r;
   logic          done_r;
   logic          done_s;
   logic          cnt_load_s;
   logic          cnt_en_s;
   logic [CW-1:0] cnt_load_val_s;
   logic          cnt_zero_s;
   logic          freeze_s;

`ifdef ALARM_BEEP_PAUSE_EN
   assign freeze_s = pause;
`else
   assign freeze_s = 1'b0;
`endif

   beep_down_counter #(.CW(CW)) u_phase_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load_s),
      .en       (cnt_en_s),
      .load_val (cnt_load_val_s),
      .count    (count),
      .zero     (cnt_zero_s)
   );

   // Next-state, counter control and done pulse; stop overrides everything
   always_comb begin
      state_s        = state_r;
      burst_left_s   = burst_left_r;
      cnt_load_s     = 1'b0;
      cnt_en_s       = 1'b0;
      cnt_load_val_s = {CW{1'b0}};
      done_s         = 1'b0;
      if (stop) begin
         state_s      = IDLE;
         burst_left_s = {BW{1'b0}};
         cnt_load_s   = 1'b1;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  state_s        = ON;
                  cnt_load_s     = 1'b1;
                  cnt_load_val_s = t_on;
                  burst_left_s   = burst;
               end else begin
                  state_s = IDLE;
               end
            end
            ON: begin
               if (tick && !freeze_s) begin
                  if (!cnt_zero_s) begin
                     cnt_en_s = 1'b1;
                  end else if (burst_left_r != {BW{1'b0}}) begin
                     state_s        = OFF;
                     cnt_load_s     = 1'b1;
                     cnt_load_val_s = t_off;
                  end else begin
                     state_s    = IDLE;
                     cnt_load_s = 1'b1;
                     done_s     = 1'b1;
                  end
               end else begin
                  state_s = ON;
               end
            end
            OFF: begin
               if (tick && !freeze_s) begin
                  if (!cnt_zero_s) begin
                     cnt_en_s = 1'b1;
                  end else begin
                     state_s        = ON;
                     cnt_load_s     = 1'b1;
                     cnt_load_val_s = t_on;
                     burst_left_s   = burst_left_r - BW'(1'b1);
                  end
               end else begin
                  state_s = OFF;
               end
            end
            default: begin
               state_s      = IDLE;
               burst_left_s = {BW{1'b0}};
               cnt_load_s   = 1'b1;
            end
         endcase
      end
   end

   // State, burst tracking and registered outputs derived from the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         burst_left_r <= {BW{1'b0}};
         beep_r       <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         burst_left_r <= burst_left_s;
         beep_r       <= (state_s == ON);
         busy_r       <= (state_s != IDLE);
         done_r       <= done_s;
      end
   end

   assign beep = beep_r;
   assign busy = busy_r;
   assign done = done_r;

endmodule

// File: tb/tb_alarm_beep_timer.sv
// Directed bench for alarm_beep_timer: vector table plus multi-cycle sequences.
module tb_alarm_beep_timer;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick;
   logic       start;
   logic       stop;
   logic [3:0] t_on;
   logic [3:0] t_off;
   logic [2:0] burst;
   logic       pause;
   logic       beep;
   logic       busy;
   logic       done;
   logic [3:0] count;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic       tick;
      logic       start;
      logic       stop;
      logic [3:0] t_on;
      logic [3:0] t_off;
      logic [2:0] burst;
      logic       beep;
      logic       busy;
      logic       done;
      logic [3:0] count;
   } vec_t;

   vec_t vecs [17];

   always #5 clk = ~clk;

   alarm_beep_timer #(.CW(4), .BW(3)) dut (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .start (start),
      .stop  (stop),
      .t_on  (t_on),
      .t_off (t_off),
      .burst (burst),
`ifdef ALARM_BEEP_PAUSE_EN
      .pause (pause),
`endif
      .beep  (beep),
      .busy  (busy),
      .done  (done),
      .count (count)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string name, input logic eb, input logic ebu,
                          input logic ed, input logic [3:0] ec);
      chk({name, ".beep"},  int'(beep),  int'(eb));
      chk({name, ".busy"},  int'(busy),  int'(ebu));
      chk({name, ".done"},  int'(done),  int'(ed));
      chk({name, ".count"}, int'(count), int'(ec));
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic tk, input logic st, input logic sp,
                        input logic [3:0] on_v, input logic [3:0] off_v, input logic [2:0] b);
      tick = tk; start = st; stop = sp; t_on = on_v; t_off = off_v; burst = b;
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 3'd0);
      pause = 1'b0;
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   function automatic logic [3:0] exp034_count(input int c);
      if (c >= 1 && c <= 5)   return 4'(5 - c);
      if (c >= 6 && c <= 10)  return 4'(10 - c);
      if (c >= 11 && c <= 15) return 4'(15 - c);
      return 4'd0;
   endfunction

   initial begin
      int beep_cycles;
      int ticks_on;
      int done_cyc;
      int done_cnt;

      // row inputs apply for one cycle; expected outputs are seen after that edge
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 4'd2, 4'd1, 3'd1, 1'b1, 1'b1, 1'b0, 4'd2};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 4'd2, 4'd1, 3'd1, 1'b1, 1'b1, 1'b0, 4'd2};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 4'd2, 4'd1, 3'd1, 1'b1, 1'b1, 1'b0, 4'd1};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 4'd9, 4'd1, 3'd5, 1'b1, 1'b1, 1'b0, 4'd0};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'd2, 4'd1, 3'd1, 1'b1, 1'b1, 1'b0, 4'd0};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 4'd2, 4'd1, 3'd1, 1'b0, 1'b1, 1'b0, 4'd1};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 4'd3, 4'd1, 3'd1, 1'b0, 1'b1, 1'b0, 4'd0};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 4'd3, 4'd1, 3'd1, 1'b1, 1'b1, 1'b0, 4'd3};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, 4'd3, 4'd1, 3'd1, 1'b1, 1'b1, 1'b0, 4'd2};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'd3, 4'd1, 3'd1, 1'b1, 1'b1, 1'b0, 4'd1};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 4'd3, 4'd1, 3'd1, 1'b1, 1'b1, 1'b0, 4'd0};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 4'd3, 4'd1, 3'd1, 1'b0, 1'b0, 1'b1, 4'd0};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 4'd3, 4'd1, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0};
      vecs[13] = '{1'b1, 1'b1, 1'b1, 4'd7, 4'd1, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0};
      vecs[14] = '{1'b1, 1'b1, 1'b0, 4'd5, 4'd1, 3'd0, 1'b1, 1'b1, 1'b0, 4'd5};
      vecs[15] = '{1'b1, 1'b1, 1'b1, 4'd5, 4'd1, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0};
      vecs[16] = '{1'b1, 1'b0, 1'b0, 4'd5, 4'd1, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0};

      // reset state
      do_reset();
      chk_out("reset", 1'b0, 1'b0, 1'b0, 4'd0);

      // vector table
      for (int i = 0; i < 17; i++) begin
         drive(vecs[i].tick, vecs[i].start, vecs[i].stop,
               vecs[i].t_on, vecs[i].t_off, vecs[i].burst);
         cyc();
         chk_out($sformatf("vec%0d", i), vecs[i].beep, vecs[i].busy,
                 vecs[i].done, vecs[i].count);
      end

      // full two-burst waveform, with start re-asserted at cycle 3
      do_reset();
      drive(1'b1, 1'b1, 1'b0, 4'd4, 4'd4, 3'd1);
      for (int c = 1; c <= 18; c++) begin
         cyc();
         chk_out($sformatf("wave_c%0d", c), (c >= 1 && c <= 5) || (c >= 11 && c <= 15),
                 (c >= 1 && c <= 15), (c == 16), exp034_count(c));
         start = (c == 3);
      end

      // stop at cycle 8
      do_reset();
      drive(1'b1, 1'b1, 1'b0, 4'd4, 4'd4, 3'd1);
      for (int c = 1; c <= 8; c++) begin
         cyc();
         start = 1'b0;
      end
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      chk_out("stop_c9", 1'b0, 1'b0, 1'b0, 4'd0);
      done_cnt = 0;
      for (int c = 10; c <= 22; c++) begin
         cyc();
         if (done) done_cnt++;
      end
      chk("stop_no_done", done_cnt, 0);
      chk("stop_stays_idle", int'(busy), 0);

      // slow tick: every 4th cycle, t_on=1, burst=0
      do_reset();
      drive(1'b0, 1'b1, 1'b0, 4'd1, 4'd0, 3'd0);
      beep_cycles = 0;
      ticks_on = 0;
      done_cyc = -1;
      for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
         cyc();
         start = 1'b0;
         if (done) done_cyc = c;
         if (beep) begin
            beep_cycles++;
            if (c % 4 == 3) ticks_on++;
         end
         tick = (c % 4 == 3);
      end
      chk("slow_done_cycle", done_cyc, 8);
      chk("slow_beep_cycles", beep_cycles, 7);
      chk("slow_ticks_on", ticks_on, 2);
      tick = 1'b1;
      done_cnt = 0;
      for (int c = 0; c < 6; c++) begin
         cyc();
         if (done || busy || beep) done_cnt++;
      end
      chk("slow_quiet_after", done_cnt, 0);

      // asynchronous reset mid-OFF, then a fresh sequence
      do_reset();
      drive(1'b1, 1'b1, 1'b0, 4'd4, 4'd4, 3'd1);
      for (int c = 1; c <= 7; c++) begin
         cyc();
         start = 1'b0;
      end
      chk("pre_rst_busy", int'(busy), 1);
      chk("pre_rst_count", int'(count), 3);
      #2;
      rst = 1'b1;
      #1;
      chk_out("async_rst", 1'b0, 1'b0, 1'b0, 4'd0);
      cyc();
      rst = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 4'd0, 4'd4, 3'd0);
      cyc();
      start = 1'b0;
      chk_out("post_rst_c1", 1'b1, 1'b1, 1'b0, 4'd0);
      cyc();
      chk_out("post_rst_c2", 1'b0, 1'b0, 1'b1, 4'd0);

`ifdef ALARM_BEEP_PAUSE_EN
      // pause three cycles while ON with count=2
      do_reset();
      drive(1'b1, 1'b1, 1'b0, 4'd4, 4'd4, 3'd0);
      done_cyc = -1;
      for (int c = 1; c <= 14; c++) begin
         cyc();
         start = 1'b0;
         if (done && done_cyc < 0) done_cyc = c;
         if (c >= 4 && c <= 6) begin
            chk($sformatf("pause_cnt_c%0d", c), int'(count), 2);
            chk($sformatf("pause_beep_c%0d", c), int'(beep), 1);
         end
         pause = (c >= 3 && c <= 5);
      end
      chk("pause_done_cycle", done_cyc, 9);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alarm_beep_timer.md
ALARM_BEEP_TIMER -- requirements
Module: alarm_beep_timer

Interface
REQ-001 Parameter CW, default 4: phase counter width in bits.
REQ-002 Parameter BW, default 3: burst counter width in bits.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 tick  input  1  count-enable strobe; a phase counter decrements only in cycles where tick=1.
REQ-006 start  input  1  one-cycle request to begin a beep sequence.
REQ-007 stop  input  1  abort request; returns to idle.
REQ-008 t_on  input  CW  ON-phase length; value N gives N+1 ticks.
REQ-009 t_off  input  CW  OFF-phase length; value N gives N+1 ticks.
REQ-010 burst  input  BW  number of ON phases minus one.
REQ-011 pause  input  1  freeze request; port exists only when ALARM_BEEP_PAUSE_EN is defined.
REQ-012 beep  output  1  buzzer enable; high exactly in the ON state.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse on normal sequence completion.
REQ-015 count  output  CW  current phase counter value.

Function
REQ-016 FSM states: IDLE, ON, OFF; beep, busy and done are registered outputs.
REQ-017 IDLE with start=1 and stop=0: next state ON, count<=t_on, burst_left<=burst.
REQ-018 ON or OFF with tick=1 and count!=0: count<=count-1 and the state is held.
REQ-019 ON with tick=1, count=0 and burst_left!=0: next state OFF, count<=t_off.
REQ-020 ON with tick=1, count=0 and burst_left=0: next state IDLE, count<=0, done=1 for one cycle.
REQ-021 OFF with tick=1 and count=0: next state ON, count<=t_on, burst_left<=burst_left-1.
REQ-022 tick=0 holds count, state and burst_left unchanged.
REQ-023 stop=1 in any state: next state IDLE, count<=0, beep<=0, done stays 0; stop has priority over start and tick.
REQ-024 start=1 while busy is ignored; a sequence is never retriggered.
REQ-025 tick in the cycle start is accepted has no effect; the first decrement occurs on the next tick.
REQ-026 t_on and t_off are sampled only at phase load; burst is sampled only at start.
REQ-027 All counter arithmetic is modulo its width; count never decrements below 0.

Reset
REQ-028 rst=1 forces, asynchronously, state=IDLE, count=0, burst_left=0, beep=0, busy=0, done=0.
REQ-029 Reset mid-sequence abandons the sequence with no done pulse; the first start after rst deasserts is honoured.

Configuration
REQ-030 With ALARM_BEEP_PAUSE_EN defined, pause=1 in ON or OFF freezes count, state and burst_left; beep keeps its value; stop still aborts.
REQ-031 With ALARM_BEEP_PAUSE_EN undefined, the pause port and pause logic are absent; behaviour otherwise identical.

Structure
REQ-032 Package alarm_beep_pkg holds: the state enum (IDLE, ON, OFF), default CW and BW, and the state encoding width.
REQ-033 Sub-module beep_down_counter: CW-bit loadable down counter with load, enable and zero flag, instantiated once for the phase counter.

Verification
REQ-034 CW=4, tick=1 continuous, t_on=4, t_off=4, burst=1, start at cycle 0: beep high cycles 1-5, low 6-10, high 11-15; done pulse at cycle 16; busy low from 16.
REQ-035 Same setup with stop at cycle 8: IDLE at cycle 9, beep=0, count=0, no done pulse.
REQ-036 tick every 4th cycle, t_on=1, t_off=0, burst=0: beep high for exactly 2 ticks, then done; burst_left never underflows.
REQ-037 start re-asserted at cycle 3 of REQ-034: no effect on the waveform; start and stop together in IDLE: stays IDLE.
REQ-038 rst asserted asynchronously mid-OFF: outputs go 0 immediately without waiting for clk; the next start begins a fresh sequence.
REQ-039 ALARM_BEEP_PAUSE_EN defined, pause held 3 cycles mid-ON with count=2: count stays 2 and the ON phase is extended by 3 cycles.
